gy26_cmd_tx: RTL and testbench

Transmit-side companion to the GY-26 compass receive path. It serialises command bytes to the compass over an 8N1 UART line. It issues a periodic angle query (0x31) autonomously and accepts one-shot host commands such as calibration start/stop and declination writes through a valid/ready handshake. After each poll byte it holds off further traffic until the receive path reports a complete response frame, or until a timeout expires.

---
 rtl/gy26_cmd_tx.sv | 171 +++++++++++++++++
 tb/tb_gy26_cmd_tx.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/gy26_cmd_tx.sv
// GY-26 command transmitter: 8N1 UART, host bytes win over the periodic 0x31 poll, 10*CPB cycles per frame.
// cmd_ready is low from handshake until the stop bit ends; after a poll byte the FSM also waits for resp_done or timeout.
module gy26_cmd_tx #(
  parameter int         CLK_HZ         = 50_000_000,
  parameter int         BAUD           = 9600,
  parameter logic [7:0] POLL_CMD       = 8'h31,
  parameter int         POLL_CYCLES    = 5_000_000,
  parameter int         TIMEOUT_CYCLES = 2_500_000
) (
  input  logic       clk0,
  input  logic       rst,
  input  logic       poll_en,
  input  logic [7:0] cmd_data,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic       resp_done,
  output logic       tx_angle,
  output logic       busy,
  output logic       query_sent,
  output logic       timeout
);
  localparam int CPB    = CLK_HZ / BAUD;
  localparam int BAUD_W = (CPB > 1) ? $clog2(CPB) : 1;
  localparam int POLL_W = (POLL_CYCLES > 1) ? $clog2(POLL_CYCLES) : 1;
  localparam int TO_W   = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CPB - 1);
  localparam logic [POLL_W-1:0] POLL_LAST = POLL_W'(POLL_CYCLES - 1);
  localparam logic [TO_W-1:0]   TO_LAST   = TO_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_WAIT_RESP
  } state_t;

  state_t            r_state;
  logic [BAUD_W-1:0] r_baud;
  logic [2:0]        r_bit;
  logic [7:0]        r_shift;
  logic              r_is_poll;
  logic [POLL_W-1:0] r_poll_cnt;
  logic              r_poll_pending;
  logic [TO_W-1:0]   r_to_cnt;
  logic              r_tx;
  logic              r_query_sent;
  logic              r_timeout;

  logic w_poll_fire;
  logic w_poll_take;
  logic w_baud_end;

  assign w_poll_fire = poll_en && (r_poll_cnt == POLL_LAST);
  assign w_poll_take = (r_state == S_IDLE) && !cmd_valid && r_poll_pending;
  assign w_baud_end  = (r_baud == BAUD_LAST);

  assign cmd_ready  = (r_state == S_IDLE) && rst;
  assign busy       = (r_state != S_IDLE);
  assign tx_angle   = r_tx;
  assign query_sent = r_query_sent;
  assign timeout    = r_timeout;

  // A new timer expiry beats the IDLE take so a request is never lost; repeats coalesce.
  always_ff @(posedge clk0) begin
    if (!rst) begin
      r_poll_cnt     <= '0;
      r_poll_pending <= 1'b0;
    end else if (!poll_en) begin
      r_poll_cnt     <= '0;
      r_poll_pending <= 1'b0;
    end else begin
      r_poll_cnt <= w_poll_fire ? '0 : r_poll_cnt + POLL_W'(1);
      if (w_poll_fire)
        r_poll_pending <= 1'b1;
      else if (w_poll_take)
        r_poll_pending <= 1'b0;
    end
  end

  always_ff @(posedge clk0) begin
    if (!rst) begin
      r_state      <= S_IDLE;
      r_baud       <= '0;
      r_bit        <= '0;
      r_shift      <= '0;
      r_is_poll    <= 1'b0;
      r_to_cnt     <= '0;
      r_tx         <= 1'b1;
      r_query_sent <= 1'b0;
      r_timeout    <= 1'b0;
    end else begin
      r_query_sent <= 1'b0;
      r_timeout    <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_tx <= 1'b1;
          if (cmd_valid) begin
            r_shift   <= cmd_data;
            r_is_poll <= 1'b0;
            r_baud    <= '0;
            r_tx      <= 1'b0;
            r_state   <= S_START;
          end else if (r_poll_pending) begin
            r_shift   <= POLL_CMD;
            r_is_poll <= 1'b1;
            r_baud    <= '0;
            r_tx      <= 1'b0;
            r_state   <= S_START;
          end
        end
        S_START: begin
          if (w_baud_end) begin
            r_baud  <= '0;
            r_bit   <= '0;
            r_tx    <= r_shift[0];
            r_state <= S_DATA;
          end else begin
            r_baud <= r_baud + BAUD_W'(1);
          end
        end
        S_DATA: begin
          // Shift right so the next line bit is always at index 1.
          if (w_baud_end) begin
            r_baud <= '0;
            if (r_bit == 3'd7) begin
              r_tx    <= 1'b1;
              r_state <= S_STOP;
            end else begin
              r_bit   <= r_bit + 3'd1;
              r_tx    <= r_shift[1];
              r_shift <= r_shift >> 1;
            end
          end else begin
            r_baud <= r_baud + BAUD_W'(1);
          end
        end
        S_STOP: begin
          r_tx <= 1'b1;
          if (w_baud_end) begin
            r_baud <= '0;
            if (r_is_poll) begin
              r_query_sent <= 1'b1;
              r_to_cnt     <= '0;
              r_state      <= S_WAIT_RESP;
            end else begin
              r_state <= S_IDLE;
            end
          end else begin
            r_baud <= r_baud + BAUD_W'(1);
          end
        end
        S_WAIT_RESP: begin
          r_tx <= 1'b1;
          if (resp_done) begin
            r_state <= S_IDLE;
          end else if (r_to_cnt == TO_LAST) begin
            r_timeout <= 1'b1;
            r_state   <= S_IDLE;
          end else begin
            r_to_cnt <= r_to_cnt + TO_W'(1);
          end
        end
        default: begin
          r_tx    <= 1'b1;
          r_state <= S_IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_gy26_cmd_tx.sv
// Directed bench for gy26_cmd_tx with CPB=10, poll period 300, response timeout 50.
module tb_gy26_cmd_tx;
  logic       clk0 = 1'b0;
  logic       rst = 1'b0;
  logic       poll_en = 1'b0;
  logic [7:0] cmd_data = 8'h00;
  logic       cmd_valid = 1'b0;
  logic       resp_done = 1'b0;
  logic       cmd_ready, tx_angle, busy, query_sent, timeout;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int n_qs = 0;
  int n_to = 0;

  gy26_cmd_tx #(
    .CLK_HZ(1000), .BAUD(100), .POLL_CMD(8'h31), .POLL_CYCLES(300), .TIMEOUT_CYCLES(50)
  ) dut (
    .clk0(clk0), .rst(rst), .poll_en(poll_en), .cmd_data(cmd_data), .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready), .resp_done(resp_done), .tx_angle(tx_angle), .busy(busy),
    .query_sent(query_sent), .timeout(timeout)
  );

  always #5 clk0 = ~clk0;
  always @(posedge clk0) cyc <= cyc + 1;
  always @(negedge clk0) begin
    if (query_sent === 1'b1) n_qs++;
    if (timeout === 1'b1) n_to++;
  end

  task automatic tick;
    @(posedge clk0);
    #1;
  endtask

  // Line monitor: waits for a start bit, samples mid-bit, returns one cycle after the stop bit ends.
  task automatic rx_frame(output logic [7:0] b, output int t_fall, output logic framed);
    int w;
    w = 0; b = 8'h00; t_fall = -1; framed = 1'b0;
    while (tx_angle !== 1'b0 && w < 1000) begin tick(); w++; end
    if (tx_angle !== 1'b0) return;
    t_fall = cyc;
    repeat (5) tick();
    framed = (tx_angle === 1'b0);
    for (int i = 0; i < 8; i++) begin
      repeat (10) tick();
      b[i] = tx_angle;
    end
    repeat (10) tick();
    framed = framed && (tx_angle === 1'b1);
    repeat (5) tick();
  endtask

  task automatic test_reset;
    rst = 1'b0;
    repeat (3) tick();
    checks++; if (tx_angle !== 1'b1) begin errors++; $display("FAIL reset_tx: got %b expected 1", tx_angle); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (cmd_ready !== 1'b0) begin errors++; $display("FAIL reset_rdy_in_reset: got %b expected 0", cmd_ready); end
    checks++; if ({query_sent, timeout} !== 2'b00) begin errors++; $display("FAIL reset_pulses: got %b expected 00", {query_sent, timeout}); end
    rst = 1'b1;
    tick();
    checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL reset_rdy_after: got %b expected 1", cmd_ready); end
    checks++; if (tx_angle !== 1'b1) begin errors++; $display("FAIL reset_tx_after: got %b expected 1", tx_angle); end
  endtask

  task automatic test_host_byte;
    logic [9:0] frame;
    int bad_line, rdy_low, qs0;
    frame = {1'b1, 8'hC0, 1'b0};
    poll_en = 1'b0;
    qs0 = n_qs;
    cmd_data = 8'hC0; cmd_valid = 1'b1;
    checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL host_rdy_before: got %b expected 1", cmd_ready); end
    tick();
    cmd_valid = 1'b0; cmd_data = 8'h3C;
    bad_line = 0; rdy_low = 0;
    for (int i = 0; i < 110; i++) begin
      if (i < 100 && tx_angle !== frame[i/10]) bad_line++;
      if (i >= 100 && tx_angle !== 1'b1) bad_line++;
      if (cmd_ready === 1'b0) rdy_low++;
      tick();
    end
    checks++; if (bad_line != 0) begin errors++; $display("FAIL host_line: got %0d wrong cycles expected 0", bad_line); end
    checks++; if (rdy_low != 100) begin errors++; $display("FAIL host_rdy_low: got %0d cycles expected 100", rdy_low); end
    checks++; if (n_qs != qs0) begin errors++; $display("FAIL host_no_query: got %0d pulses expected 0", n_qs - qs0); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL host_idle: got busy %b expected 0", busy); end
  endtask

  task automatic test_periodic_poll;
    logic [7:0] b; int tf, c0, qs0, to0; logic fr;
    qs0 = n_qs; to0 = n_to;
    poll_en = 1'b1; c0 = cyc;
    for (int p = 1; p <= 2; p++) begin
      rx_frame(b, tf, fr);
      checks++; if (b !== 8'h31 || fr !== 1'b1) begin errors++; $display("FAIL poll_byte%0d: got %h framed %b expected 31 framed 1", p, b, fr); end
      checks++; if (tf - c0 != 300 * p + 1) begin errors++; $display("FAIL poll_time%0d: got %0d expected %0d", p, tf - c0, 300 * p + 1); end
      checks++; if (query_sent !== 1'b1) begin errors++; $display("FAIL poll_qs%0d: got %b expected 1", p, query_sent); end
      repeat (20) tick();
      resp_done = 1'b1; tick(); resp_done = 1'b0;
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL poll_resp_idle%0d: got busy %b expected 0", p, busy); end
    end
    repeat (60) tick();
    poll_en = 1'b0;
    checks++; if (n_qs - qs0 != 2) begin errors++; $display("FAIL poll_qs_count: got %0d expected 2", n_qs - qs0); end
    checks++; if (n_to != to0) begin errors++; $display("FAIL poll_no_timeout: got %0d expected 0", n_to - to0); end
    tick();
  endtask

  task automatic test_timeout;
    logic [7:0] b; int tf, c0, to0; logic fr;
    poll_en = 1'b1; c0 = cyc;
    rx_frame(b, tf, fr);
    checks++; if (b !== 8'h31 || tf - c0 != 301) begin errors++; $display("FAIL to_first_poll: got %h at %0d expected 31 at 301", b, tf - c0); end
    to0 = n_to;
    repeat (49) tick();
    checks++; if (timeout !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL to_early: got to %b busy %b expected 0 1", timeout, busy); end
    tick();
    checks++; if (timeout !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL to_pulse: got to %b busy %b expected 1 0", timeout, busy); end
    tick();
    checks++; if (timeout !== 1'b0 || n_to - to0 != 1) begin errors++; $display("FAIL to_single: got to %b count %0d expected 0 1", timeout, n_to - to0); end
    rx_frame(b, tf, fr);
    checks++; if (b !== 8'h31 || fr !== 1'b1 || tf - c0 != 601) begin errors++; $display("FAIL to_next_poll: got %h at %0d expected 31 at 601", b, tf - c0); end
    resp_done = 1'b1; tick(); resp_done = 1'b0;
    poll_en = 1'b0;
    tick();
  endtask

  task automatic test_collision;
    logic [7:0] b; int tf, c0, qs0, to0; logic fr;
    qs0 = n_qs;
    poll_en = 1'b1; c0 = cyc;
    repeat (300) tick();
    cmd_data = 8'hA5; cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0; cmd_data = 8'h00;
    rx_frame(b, tf, fr);
    checks++; if (b !== 8'hA5 || fr !== 1'b1 || tf - c0 != 301) begin errors++; $display("FAIL coll_host_first: got %h at %0d expected a5 at 301", b, tf - c0); end
    checks++; if (n_qs != qs0) begin errors++; $display("FAIL coll_host_no_qs: got %0d expected 0", n_qs - qs0); end
    rx_frame(b, tf, fr);
    checks++; if (b !== 8'h31 || fr !== 1'b1 || tf - c0 != 402) begin errors++; $display("FAIL coll_poll_next: got %h at %0d expected 31 at 402", b, tf - c0); end
    checks++; if (query_sent !== 1'b1) begin errors++; $display("FAIL coll_qs: got %b expected 1", query_sent); end
    to0 = n_to;
    repeat (49) tick();
    resp_done = 1'b1; tick(); resp_done = 1'b0;
    checks++; if (timeout !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL coll_resp_wins: got to %b busy %b expected 0 0", timeout, busy); end
    repeat (5) tick();
    poll_en = 1'b0;
    checks++; if (n_to != to0) begin errors++; $display("FAIL coll_no_timeout: got %0d expected 0", n_to - to0); end
    tick();
  endtask

  task automatic test_reset_mid_data;
    logic [7:0] b; int tf, ths, lows; logic fr;
    cmd_data = 8'hFF; cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
    repeat (55) tick();
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL rmid_busy_before: got %b expected 1", busy); end
    rst = 1'b0;
    tick();
    checks++; if (tx_angle !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL rmid_reset: got tx %b busy %b expected 1 0", tx_angle, busy); end
    checks++; if (cmd_ready !== 1'b0) begin errors++; $display("FAIL rmid_rdy_in_reset: got %b expected 0", cmd_ready); end
    tick();
    rst = 1'b1;
    lows = 0;
    for (int i = 0; i < 30; i++) begin
      if (tx_angle !== 1'b1) lows++;
      tick();
    end
    checks++; if (lows != 0 || busy !== 1'b0) begin errors++; $display("FAIL rmid_no_glitch: got %0d low cycles busy %b expected 0 0", lows, busy); end
    cmd_data = 8'h55; cmd_valid = 1'b1; ths = cyc;
    tick();
    cmd_valid = 1'b0; cmd_data = 8'hAA;
    rx_frame(b, tf, fr);
    checks++; if (b !== 8'h55 || fr !== 1'b1 || tf != ths + 1) begin errors++; $display("FAIL rmid_new_byte: got %h framed %b at +%0d expected 55 1 at +1", b, fr, tf - ths); end
    checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL rmid_rdy_after: got %b expected 1", cmd_ready); end
  endtask

  initial begin
    test_reset();
    test_host_byte();
    test_periodic_poll();
    test_timeout();
    test_collision();
    test_reset_mid_data();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
